// File: rtl/stopwatch_digit_src.sv
// ============================================================================
// Module   : stopwatch_digit_src
// Brief    : MM:SS BCD stopwatch with run/pause FSM and free-running scan
//            select for the four-digit 14-segment scan stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_digit_src #(
    parameter int TICK_DIV = 40_000_000,
    parameter int SCAN_DIV = 20_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [1:0] ftsd_ctl_en,
    output logic       running,
    output logic       wrap
);

    localparam int c_pre_w  = $clog2(TICK_DIV);
    localparam int c_scan_w = $clog2(SCAN_DIV);

    localparam logic [c_pre_w-1:0]  c_pre_max  = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_pre_w-1:0]  c_pre_one  = c_pre_w'(1);
    localparam logic [c_scan_w-1:0] c_scan_max = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_scan_w-1:0] c_scan_one = c_scan_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_pause = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                w_running_next;
    logic                r_running;
    logic [c_pre_w-1:0]  r_pre;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [1:0]          r_sel;
    logic [3:0]          r_d0, r_d1, r_d2, r_d3;
    logic                r_wrap;
    logic                w_tick;
    logic                w_c3, w_c2, w_c1, w_c0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // clear wins over start_stop; a held start_stop toggles every cycle
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = c_idle;
        end else if (start_stop) begin
            case (r_state)
                c_idle:  w_next_state = c_run;
                c_run:   w_next_state = c_pause;
                c_pause: w_next_state = c_run;
                default: w_next_state = c_idle;
            endcase
        end
    end

    always_comb begin
        w_running_next = (w_next_state == c_run);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_running <= 1'b0;
        end else begin
            r_running <= w_running_next;
        end
    end

    // Advance is keyed on the pre-edge state, so a pause on the wrap edge still counts
    assign w_tick = (r_state == c_run) && (r_pre == c_pre_max) && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_pre <= '0;
        end else if (r_state == c_run) begin
            r_pre <= (r_pre == c_pre_max) ? '0 : r_pre + c_pre_one;
        end
    end

    assign w_c3 = w_tick && (r_d3 == 4'd9);
    assign w_c2 = w_c3   && (r_d2 == 4'd5);
    assign w_c1 = w_c2   && (r_d1 == 4'd9);
    assign w_c0 = w_c1   && (r_d0 == 4'd5);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_d0   <= 4'd0;
            r_d1   <= 4'd0;
            r_d2   <= 4'd0;
            r_d3   <= 4'd0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_c0;
            if (w_tick) r_d3 <= w_c3 ? 4'd0 : r_d3 + 4'd1;
            if (w_c3)   r_d2 <= w_c2 ? 4'd0 : r_d2 + 4'd1;
            if (w_c2)   r_d1 <= w_c1 ? 4'd0 : r_d1 + 4'd1;
            if (w_c1)   r_d0 <= w_c0 ? 4'd0 : r_d0 + 4'd1;
        end
    end

    // Scan select ignores clear and the FSM entirely
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_sel      <= 2'b00;
        end else if (r_scan_cnt == c_scan_max) begin
            r_scan_cnt <= '0;
            r_sel      <= r_sel + 2'b01;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_scan_one;
        end
    end

    assign dig0        = r_d0;
    assign dig1        = r_d1;
    assign dig2        = r_d2;
    assign dig3        = r_d3;
    assign ftsd_ctl_en = r_sel;
    assign running     = r_running;
    assign wrap        = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_digit_src.sv
// ============================================================================
// Module   : tb_stopwatch_digit_src
// Brief    : Directed self-checking bench for stopwatch_digit_src.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_digit_src;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [1:0] ftsd_ctl_en;
    logic       running;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    int n_edges = 0;
    int wrap_seen = 0;

    stopwatch_digit_src #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_stop  (start_stop),
        .clear       (clear),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .ftsd_ctl_en (ftsd_ctl_en),
        .running     (running),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    // Independent scan reference: select = (edges since reset / 2) mod 4
    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_seen = wrap_seen + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] time_now();
        return {16'h0, dig0, dig1, dig2, dig3};
    endfunction

    function automatic logic [31:0] scan_exp();
        logic [31:0] n;
        n = n_edges;
        return {30'h0, n[2:1]};
    endfunction

    task automatic pulse_start();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    initial begin
        logic [1:0] scan_tbl [9] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                                     2'b10, 2'b11, 2'b11, 2'b00};

        // Reset
        step(3);
        rst = 1'b0;
        chk("reset_digits", time_now(), 32'h0000);
        chk("reset_scan", {30'h0, ftsd_ctl_en}, 32'h0);
        chk("reset_running", {31'h0, running}, 32'h0);
        chk("reset_wrap", {31'h0, wrap}, 32'h0);

        // Scan free-run from reset
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("scan_seq_%0d", i), {30'h0, ftsd_ctl_en}, {30'h0, scan_tbl[i]});
            if (i < 8) step(1);
        end

        // Idle holds
        step(50);
        chk("idle_digits", time_now(), 32'h0000);
        chk("idle_running", {31'h0, running}, 32'h0);
        chk("idle_scan", {30'h0, ftsd_ctl_en}, scan_exp());

        // Count from E0
        pulse_start();
        chk("cnt_running", {31'h0, running}, 32'h1);
        chk("cnt_e0", time_now(), 32'h0000);
        step(3);
        chk("cnt_e3", time_now(), 32'h0000);
        step(1);
        chk("cnt_e4", time_now(), 32'h0001);
        step(36);
        chk("cnt_e40", time_now(), 32'h0010);
        chk("cnt_scan", {30'h0, ftsd_ctl_en}, scan_exp());
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_digits", time_now(), 32'h0000);
        chk("clr_running", {31'h0, running}, 32'h0);
        chk("clr_scan", {30'h0, ftsd_ctl_en}, scan_exp());

        // Pause at E0+6 with the prescaler at 2, then resume
        pulse_start();
        step(5);
        pulse_start();
        chk("pause_running", {31'h0, running}, 32'h0);
        chk("pause_digits", time_now(), 32'h0001);
        step(20);
        chk("pause_hold", time_now(), 32'h0001);
        pulse_start();
        chk("resume_running", {31'h0, running}, 32'h1);
        step(1);
        chk("resume_r1", time_now(), 32'h0001);
        step(1);
        chk("resume_r2", time_now(), 32'h0002);

        // Priority: clear with start_stop in RUN at 00:05
        step(12);
        chk("prio_pre", time_now(), 32'h0005);
        clear = 1'b1;
        start_stop = 1'b1;
        step(1);
        clear = 1'b0;
        start_stop = 1'b0;
        chk("prio_digits", time_now(), 32'h0000);
        chk("prio_running", {31'h0, running}, 32'h0);

        // Clear on a prescaler-wrap edge
        pulse_start();
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clrwrap_digits", time_now(), 32'h0000);
        chk("clrwrap_wrap", {31'h0, wrap}, 32'h0);
        chk("clrwrap_running", {31'h0, running}, 32'h0);
        step(8);
        chk("clrwrap_idle", time_now(), 32'h0000);

        // Full rollover 59:59 -> 00:00
        wrap_seen = 0;
        pulse_start();
        step(14395);
        chk("wrap_5958", time_now(), 32'h5958);
        step(1);
        chk("wrap_5959", time_now(), 32'h5959);
        chk("wrap_early", {31'h0, wrap}, 32'h0);
        step(3);
        chk("wrap_hold", time_now(), 32'h5959);
        step(1);
        chk("wrap_digits", time_now(), 32'h0000);
        chk("wrap_pulse", {31'h0, wrap}, 32'h1);
        chk("wrap_running", {31'h0, running}, 32'h1);
        step(1);
        chk("wrap_low", {31'h0, wrap}, 32'h0);
        step(3);
        chk("wrap_continue", time_now(), 32'h0001);
        chk("wrap_count", wrap_seen, 32'd1);
        chk("wrap_scan", {30'h0, ftsd_ctl_en}, scan_exp());

        // Reset mid-run
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_run_digits", time_now(), 32'h0000);
        chk("rst_run_running", {31'h0, running}, 32'h0);
        chk("rst_run_scan", {30'h0, ftsd_ctl_en}, 32'h0);
        chk("rst_run_wrap", {31'h0, wrap}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
